// File: rtl/audio_i2s_transmitter_pkg.sv
// Shared definitions for the I2S transmitter: channel encoding and default sample width.
package audio_i2s_transmitter_pkg;

    localparam int DEFAULT_WORD_BYTES = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

endpackage

// File: rtl/audio_i2s_transmitter_if.sv
// AXI-stream style sample handshake between a sample source (master) and the transmitter (slave).
interface audio_i2s_transmitter_if #(
    parameter int W = 16
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/audio_i2s_transmitter_clock_gen.sv
// BCLK/LRCLK generator: divides clk into BCLK, counts bits within a slot and
// flags each BCLK falling edge and the first falling edge of every slot.
module audio_i2s_transmitter_clock_gen #(
    parameter int BCLK_DIV = 4,
    parameter int W        = 16
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic lrclk,
    output logic fe_strobe,
    output logic slot_start
);
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int KW = $clog2(W);

    logic [CW-1:0] div_cnt;
    logic [KW-1:0] bit_idx;
    logic          term;

    assign term       = (div_cnt == CW'(BCLK_DIV - 1));
    // The cycle in which bclk is about to go 1->0.
    assign fe_strobe  = term & bclk;
    assign slot_start = fe_strobe & (bit_idx == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bit_idx <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b1;
        end else begin
            if (term) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fe_strobe) begin
                bit_idx <= (bit_idx == KW'(W - 1)) ? '0 : bit_idx + 1'b1;
                if (bit_idx == '0)
                    lrclk <= ~lrclk;
            end
        end
    end
endmodule

// File: rtl/audio_i2s_transmitter.sv
// Philips I2S transmitter (clock master) fed by a one-word AXI-stream buffer.
// Define AUDIO_I2S_TX_HOLD_LAST_EN to repeat each channel's last word on underrun.
module audio_i2s_transmitter
    import audio_i2s_transmitter_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    audio_i2s_transmitter_if.slave        axis,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun
);
    localparam int W = 8 * WORD_BYTES;

    logic         fe_strobe;
    logic         slot_start;
    logic [W-1:0] buffer;
    logic         buf_full;
    logic         buf_full_next;
    logic         tready_q;
    logic         transfer;
    logic [W-1:0] shifter;
    logic [W-1:0] next_word;

    audio_i2s_transmitter_clock_gen #(
        .BCLK_DIV (BCLK_DIV),
        .W        (W)
    ) u_clock_gen (
        .clk        (clk),
        .reset      (reset),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .fe_strobe  (fe_strobe),
        .slot_start (slot_start)
    );

    assign axis.tready = tready_q;
    assign transfer    = axis.tvalid & tready_q;

`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
    channel_t     slot_ch;
    logic [W-1:0] hold_q [2];

    // lrclk toggles on the slot-start edge, so the incoming slot is its inverse.
    assign slot_ch = channel_t'(~lrclk);
`endif

    // NOTE: every combinational output gets a default before any conditional
    // override, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_word = '0;
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
        next_word = hold_q[slot_ch];
`endif
        if (buf_full)
            next_word = buffer;

        buf_full_next = buf_full;
        if (slot_start && buf_full)
            buf_full_next = 1'b0;
        else if (transfer)
            buf_full_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer   <= '0;
            buf_full <= 1'b0;
            tready_q <= 1'b0;
            shifter  <= '0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            buf_full <= buf_full_next;
            tready_q <= ~buf_full_next;
            if (transfer)
                buffer <= axis.tdata;
            underrun <= slot_start & ~buf_full;
            // MSB of the shifter is always the next bit out; at slot start it is
            // still the previous word's LSB, giving the one-BCLK I2S delay.
            if (fe_strobe) begin
                sdata   <= shifter[W-1];
                shifter <= slot_start ? next_word : {shifter[W-2:0], 1'b0};
            end
        end
    end

`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
    // NOTE: the hold registers are plain flops that must read as silence after
    // reset, so unlike a RAM they are cleared explicitly element by element.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++)
                hold_q[i] <= '0;
        end else if (slot_start) begin
            hold_q[slot_ch] <= next_word;
        end
    end
`endif
endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Directed bench for audio_i2s_transmitter: drives the sample handshake and decodes the I2S stream.
module tb_audio_i2s_transmitter;
    import audio_i2s_transmitter_pkg::*;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bclk, lrclk, sdata, underrun;

    always #5 clk = ~clk;

    audio_i2s_transmitter_if #(.W(W)) axis ();

    audio_i2s_transmitter #(
        .WORD_BYTES (2),
        .BCLK_DIV   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .axis     (axis),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ur_count = 0;

    // Decoded words: {channel, data}
    logic [W:0]   dq [$];
    logic         dec_lr      = 1'b1;
    logic         dec_started = 1'b0;
    logic [W-1:0] dec_acc     = '0;

    // cyc equals the number of clk edges since reset release.
    always @(posedge clk) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (reset)                 ur_count = 0;
        else if (underrun === 1'b1) ur_count = ur_count + 1;
    end

    // I2S receiver: sample on rising bclk; a sample where lrclk changed carries
    // the LSB of the word from the previous slot.
    always @(posedge bclk or posedge reset) begin
        if (reset) begin
            dq.delete();
            dec_lr      = 1'b1;
            dec_started = 1'b0;
            dec_acc     = '0;
        end else begin
            #1;
            if (lrclk !== dec_lr) begin
                if (dec_started)
                    dq.push_back({dec_lr, dec_acc[W-2:0], sdata});
                dec_started = 1'b1;
                dec_acc     = '0;
                dec_lr      = lrclk;
            end else begin
                dec_acc = {dec_acc[W-2:0], sdata};
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b1;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_q(input int n);
        int b = 0;
        while (dq.size() < n && b < 3000) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (dq.size() < n) $display("FAIL decode_timeout: got %0d words, want %0d", dq.size(), n);
        else n_pass++;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [W-1:0] w, input bit keep_valid, output int acc_cyc);
        int b = 0;
        axis.tvalid = 1'b1;
        axis.tdata  = w;
        while (axis.tready !== 1'b1 && b < 500) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (axis.tready !== 1'b1) $display("FAIL accept_timeout: word %h not accepted", w);
        else n_pass++;
        acc_cyc = cyc + 1;
        @(negedge clk);
        if (!keep_valid) axis.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b1;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (bclk !== 1'b0)        $display("FAIL reset_bclk: got %b want 0", bclk); else n_pass++;
        if (lrclk !== 1'b1)       $display("FAIL reset_lrclk: got %b want 1", lrclk); else n_pass++;
        if (sdata !== 1'b0)       $display("FAIL reset_sdata: got %b want 0", sdata); else n_pass++;
        if (axis.tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", axis.tready); else n_pass++;
        if (underrun !== 1'b0)    $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (axis.tready !== 1'b1) $display("FAIL release_tready: got %b want 1", axis.tready); else n_pass++;
    endtask

    task automatic test_basic_frame();
        int a;
        apply_reset();
        send_word(16'hA5C3, 1'b0, a);
        wait_cyc(4);
        n_checks += 2;
        if (lrclk !== 1'b0) $display("FAIL basic_lrclk_fall: got %b want 0", lrclk); else n_pass++;
        if (sdata !== 1'b0) $display("FAIL basic_k0_bit: got %b want 0", sdata); else n_pass++;
        send_word(16'h0F0F, 1'b0, a);
        wait_cyc(7);
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL basic_pre_msb: got %b want 0", sdata); else n_pass++;
        wait_cyc(8);
        n_checks++;
        if (sdata !== 1'b1) $display("FAIL basic_msb_2nd_fe: got %b want 1", sdata); else n_pass++;
        wait_q(2);
        n_checks += 2;
        if (dq[0] !== {1'b0, 16'hA5C3}) $display("FAIL basic_left: got %h want %h", dq[0], {1'b0, 16'hA5C3}); else n_pass++;
        if (dq[1] !== {1'b1, 16'h0F0F}) $display("FAIL basic_right: got %h want %h", dq[1], {1'b1, 16'h0F0F}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [8];
        int           acc [8];
        words = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            send_word(words[i], 1'b1, acc[i]);
            n_checks++;
            if (axis.tready !== 1'b0) $display("FAIL b2b_tready_low[%0d]: got %b want 0", i, axis.tready); else n_pass++;
        end
        axis.tvalid = 1'b0;
        n_checks += 2;
        if (acc[0] !== 2) $display("FAIL b2b_accept0_cycle: got %0d want 2", acc[0]); else n_pass++;
        if (acc[1] !== 5) $display("FAIL b2b_accept1_cycle: got %0d want 5", acc[1]); else n_pass++;
        for (int i = 2; i < 8; i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] !== 64) $display("FAIL b2b_gap[%0d]: got %0d want 64", i, acc[i] - acc[i-1]); else n_pass++;
        end
        wait_q(8);
        for (int i = 0; i < 8; i++) begin
            logic [W:0] exp;
            exp = {(i % 2 == 1), words[i]};
            n_checks++;
            if (dq[i] !== exp) $display("FAIL b2b_word[%0d]: got %h want %h", i, dq[i], exp); else n_pass++;
        end
    endtask

    task automatic test_underrun();
        int         a;
        logic [W:0] exp_l2;
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
        exp_l2 = {1'b0, 16'h8000};
`else
        exp_l2 = {1'b0, 16'h0000};
`endif
        apply_reset();
        send_word(16'h8000, 1'b0, a);
        wait_cyc(262);
        n_checks++;
        if (ur_count !== 4) $display("FAIL underrun_pulses: got %0d want 4", ur_count); else n_pass++;
        wait_q(4);
        n_checks += 4;
        if (dq[0] !== {1'b0, 16'h8000}) $display("FAIL underrun_l0: got %h want %h", dq[0], {1'b0, 16'h8000}); else n_pass++;
        if (dq[1] !== {1'b1, 16'h0000}) $display("FAIL underrun_r0: got %h want %h", dq[1], {1'b1, 16'h0000}); else n_pass++;
        if (dq[2] !== exp_l2)           $display("FAIL underrun_l1: got %h want %h", dq[2], exp_l2); else n_pass++;
        if (dq[3] !== {1'b1, 16'h0000}) $display("FAIL underrun_r1: got %h want %h", dq[3], {1'b1, 16'h0000}); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int a;
        apply_reset();
        send_word(16'h1234, 1'b0, a);
        send_word(16'h5678, 1'b0, a);
        send_word(16'h9ABC, 1'b0, a);
        // Reset takes effect on edge 96: k=7 of the right slot.
        wait_cyc(95);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (bclk !== 1'b0)        $display("FAIL midrst_bclk: got %b want 0", bclk); else n_pass++;
        if (lrclk !== 1'b1)       $display("FAIL midrst_lrclk: got %b want 1", lrclk); else n_pass++;
        if (sdata !== 1'b0)       $display("FAIL midrst_sdata: got %b want 0", sdata); else n_pass++;
        if (axis.tready !== 1'b0) $display("FAIL midrst_tready: got %b want 0", axis.tready); else n_pass++;
        if (underrun !== 1'b0)    $display("FAIL midrst_underrun: got %b want 0", underrun); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(6);
        n_checks++;
        if (ur_count !== 1) $display("FAIL midrst_dropped_word: underruns got %0d want 1", ur_count); else n_pass++;
        wait_q(1);
        n_checks++;
        if (dq[0] !== {1'b0, 16'h0000}) $display("FAIL midrst_first_slot: got %h want %h", dq[0], {1'b0, 16'h0000}); else n_pass++;
    endtask

    task automatic test_bit_exact();
        int a;
        apply_reset();
        send_word(16'h7FFF, 1'b0, a);
        send_word(16'h0001, 1'b0, a);
        wait_cyc(8);
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL exact_l_msb: got %b want 0", sdata); else n_pass++;
        wait_cyc(12);
        n_checks++;
        if (sdata !== 1'b1) $display("FAIL exact_l_bit14: got %b want 1", sdata); else n_pass++;
        wait_cyc(68);
        n_checks += 2;
        if (lrclk !== 1'b1) $display("FAIL exact_r_lrclk: got %b want 1", lrclk); else n_pass++;
        if (sdata !== 1'b1) $display("FAIL exact_r_k0_lsb: got %b want 1", sdata); else n_pass++;
        wait_cyc(69);
        n_checks++;
        if (sdata !== 1'b1) $display("FAIL exact_hold_between_fe: got %b want 1", sdata); else n_pass++;
        wait_cyc(72);
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL exact_r_msb: got %b want 0", sdata); else n_pass++;
        wait_cyc(132);
        n_checks += 2;
        if (lrclk !== 1'b0) $display("FAIL exact_l2_lrclk: got %b want 0", lrclk); else n_pass++;
        if (sdata !== 1'b1) $display("FAIL exact_l2_k0_lsb: got %b want 1", sdata); else n_pass++;
        wait_cyc(136);
        n_checks++;
        if (sdata !== 1'b0) $display("FAIL exact_l2_msb: got %b want 0", sdata); else n_pass++;
        wait_q(2);
        n_checks += 2;
        if (dq[0] !== {1'b0, 16'h7FFF}) $display("FAIL exact_left: got %h want %h", dq[0], {1'b0, 16'h7FFF}); else n_pass++;
        if (dq[1] !== {1'b1, 16'h0001}) $display("FAIL exact_right: got %h want %h", dq[1], {1'b1, 16'h0001}); else n_pass++;
    endtask

    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        test_bit_exact();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
